// File: rtl/guess_player.sv
// Binary-search player for the number-guessing game; drives guesses, consumes
// higher/lower/equal feedback and reports the outcome. State changes on falling clk.
module guess_player #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_TRIES = 9,
    parameter int unsigned TW        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] LL,
    input  logic [WIDTH-1:0] HL,
    input  logic             fb_valid,
    input  logic [1:0]       fb_code,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    output logic             found,
    output logic             fail,
    output logic [1:0]       err_code,
    output logic [TW-1:0]    tries
);

    localparam logic [1:0] FB_LOW   = 2'b00;
    localparam logic [1:0] FB_HIGH  = 2'b01;
    localparam logic [1:0] FB_EQUAL = 2'b10;
    localparam logic [1:0] FB_OOR   = 2'b11;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_OOR   = 2'b10;
    localparam logic [1:0] ERR_TRIES = 2'b11;

    localparam logic [TW-1:0] TRY_LIMIT = TW'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] lo, lo_n;
    logic [WIDTH-1:0] hi, hi_n;
    logic [WIDTH-1:0] guess_n;
    logic             guess_valid_n;
    logic             found_n;
    logic             fail_n;
    logic [1:0]       err_code_n;
    logic [TW-1:0]    tries_n;

    // State and every output are registered on the falling edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            lo          <= '0;
            hi          <= '0;
            guess       <= '0;
            guess_valid <= 1'b0;
            found       <= 1'b0;
            fail        <= 1'b0;
            err_code    <= ERR_NONE;
            tries       <= '0;
        end else begin
            state       <= state_n;
            lo          <= lo_n;
            hi          <= hi_n;
            guess       <= guess_n;
            guess_valid <= guess_valid_n;
            found       <= found_n;
            fail        <= fail_n;
            err_code    <= err_code_n;
            tries       <= tries_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n       = state;
        lo_n          = lo;
        hi_n          = hi;
        guess_n       = guess;
        guess_valid_n = guess_valid;
        found_n       = found;
        fail_n        = fail;
        err_code_n    = err_code;
        tries_n       = tries;

        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    found_n    = 1'b0;
                    fail_n     = 1'b0;
                    err_code_n = ERR_NONE;
                    tries_n    = '0;
                    if (LL > HL) begin
                        state_n    = S_FAIL;
                        fail_n     = 1'b1;
                        err_code_n = ERR_RANGE;
                    end else begin
                        lo_n    = LL;
                        hi_n    = HL;
                        state_n = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                // lo <= hi always holds here, so the midpoint never exceeds hi.
                guess_n       = lo + ((hi - lo) >> 1);
                guess_valid_n = 1'b1;
                tries_n       = tries + TW'(1);
                state_n       = S_WAIT;
            end

            S_WAIT: begin
                if (fb_valid) begin
                    guess_valid_n = 1'b0;
                    case (fb_code)
                        FB_EQUAL: begin
                            found_n = 1'b1;
                            state_n = S_DONE;
                        end
                        FB_OOR: begin
                            fail_n     = 1'b1;
                            err_code_n = ERR_OOR;
                            state_n    = S_FAIL;
                        end
                        FB_LOW: begin
                            if (guess == hi) begin
                                fail_n     = 1'b1;
                                err_code_n = ERR_RANGE;
                                state_n    = S_FAIL;
                            end else if (tries == TRY_LIMIT) begin
                                fail_n     = 1'b1;
                                err_code_n = ERR_TRIES;
                                state_n    = S_FAIL;
                            end else begin
                                lo_n    = guess + WIDTH'(1);
                                state_n = S_ISSUE;
                            end
                        end
                        FB_HIGH: begin
                            // guess == lo would step below the range (and wrap at 0).
                            if (guess == lo) begin
                                fail_n     = 1'b1;
                                err_code_n = ERR_RANGE;
                                state_n    = S_FAIL;
                            end else if (tries == TRY_LIMIT) begin
                                fail_n     = 1'b1;
                                err_code_n = ERR_TRIES;
                                state_n    = S_FAIL;
                            end else begin
                                hi_n    = guess - WIDTH'(1);
                                state_n = S_ISSUE;
                            end
                        end
                        default: begin
                            state_n = S_WAIT;
                        end
                    endcase
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
